// File: rtl/cdm16_err_accum.sv
// cdm16_err_accum: on-chip accuracy statistics for the cdm16 approximate
// 16x16 multiplier. Each accepted sample (a, b, r) has its exact product
// P = a*b recomputed and its error distance ED = |P - r| accumulated. A run
// ends after N_SAMPLES accepts.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start           pulse; clears statistics and starts a run (IDLE/DONE only)
//   in_valid/ready  sample handshake; a, b (unsigned operands), r (approx product)
//   busy            run in progress (RUN or DRAIN)
//   done            run complete, statistics final
//   sample_cnt      samples accumulated
//   err_cnt         samples with ED != 0
//   ed_sum          saturating sum of ED
//   ed_max          largest ED seen
//   sum_ovf         sticky flag, ed_sum saturated during this run
module cdm16_err_accum #(
  parameter int N_SAMPLES = 1000000,
  parameter int CNT_W     = 20,
  parameter int SUM_W     = 52
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [31:0]      r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] ed_sum,
  output logic [31:0]      ed_max,
  output logic             sum_ovf
);

  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_SAMPLES - 1);
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;
  logic             drain_cnt;
  logic [STAGES:1]  vld_pipe;
  logic [15:0]      a_q, b_q;
  logic [31:0]      r_q, ed_q;
  logic [31:0]      prod, ed_c;
  logic [SUM_W:0]   sum_ext;
  logic             accept, clr;

  assign accept  = in_valid & in_ready;
  assign clr     = start & ((state == IDLE) | (state == DONE));
  assign prod    = 32'(a_q) * 32'(b_q);
  // Magnitude of the difference without wrap, whichever side is larger.
  assign ed_c    = (prod >= r_q) ? (prod - r_q) : (r_q - prod);
  // One extra bit catches the carry out that signals saturation.
  assign sum_ext = {1'b0, ed_sum} + (SUM_W+1)'(ed_q);

  // Stage 1 captures the sample, stage 2 holds the error distance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      ed_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        a_q <= a;
        b_q <= b;
        r_q <= r;
      end
      if (vld_pipe[1]) ed_q <= ed_c;
    end
  end

  // Statistics. The pipeline is always empty when start is honoured
  // (IDLE after reset, DONE after the drain), so clear never races an update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sum_ovf    <= 1'b0;
    end else if (clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sum_ovf    <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (ed_q != '0) err_cnt <= err_cnt + CNT_W'(1);
      if (sum_ext[SUM_W]) begin
        ed_sum  <= SUM_MAX;
        sum_ovf <= 1'b1;
      end else begin
        ed_sum  <= sum_ext[SUM_W-1:0];
      end
      if (ed_q > ed_max) ed_max <= ed_q;
    end
  end

  // Run control with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      drain_cnt <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state    <= RUN;
          acc_cnt  <= '0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
        end
        RUN: if (accept) begin
          acc_cnt <= acc_cnt + CNT_W'(1);
          if (acc_cnt == LAST) begin
            state     <= DRAIN;
            in_ready  <= 1'b0;
            drain_cnt <= 1'b0;
          end
        end
        // Two cycles: one per pipeline stage still holding the last sample.
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdm16_err_accum.sv
module tb_cdm16_err_accum;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [15:0] a, b;
  logic [31:0] r;
  logic st0, st1, st2;

  // u0: N=4, SUM_W=52 (main runs, scoreboard-checked)
  logic rdy0, busy0, done0, ov0;
  logic [19:0] sc0, ec0;
  logic [51:0] es0;
  logic [31:0] em0;
  // u1: N=1
  logic rdy1, busy1, done1, ov1;
  logic [19:0] sc1, ec1;
  logic [51:0] es1;
  logic [31:0] em1;
  // u2: N=3, SUM_W=33 (saturation)
  logic rdy2, busy2, done2, ov2;
  logic [19:0] sc2, ec2;
  logic [32:0] es2;
  logic [31:0] em2;

  always #5 clk = ~clk;

  cdm16_err_accum #(.N_SAMPLES(4), .CNT_W(20), .SUM_W(52)) u0 (
    .clk(clk), .rst(rst), .start(st0), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .r(r), .busy(busy0), .done(done0), .sample_cnt(sc0),
    .err_cnt(ec0), .ed_sum(es0), .ed_max(em0), .sum_ovf(ov0));

  cdm16_err_accum #(.N_SAMPLES(1), .CNT_W(20), .SUM_W(52)) u1 (
    .clk(clk), .rst(rst), .start(st1), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .r(r), .busy(busy1), .done(done1), .sample_cnt(sc1),
    .err_cnt(ec1), .ed_sum(es1), .ed_max(em1), .sum_ovf(ov1));

  cdm16_err_accum #(.N_SAMPLES(3), .CNT_W(20), .SUM_W(33)) u2 (
    .clk(clk), .rst(rst), .start(st2), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .r(r), .busy(busy2), .done(done2), .sample_cnt(sc2),
    .err_cnt(ec2), .ed_sum(es2), .ed_max(em2), .sum_ovf(ov2));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] r;
    logic [31:0] ed;   // expected error distance
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [19:0] sc;
    logic [19:0] ec;
    logic [63:0] es;
    logic [31:0] em;
    logic        ov;
  } sb_t;

  localparam logic [63:0] MAX52 = 64'h000F_FFFF_FFFF_FFFF;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  logic [31:0] cur_ed = '0;
  sb_t q[$];
  sb_t m = '{0, '0, '0, '0, '0, 1'b0};
  vec_t tv[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ed_of(logic [15:0] va, logic [15:0] vb, logic [31:0] vr);
    logic [31:0] p;
    p = 32'(va) * 32'(vb);
    return (p >= vr) ? (p - vr) : (vr - p);
  endfunction

  // Scoreboard push: running expected statistics for u0, due 2 edges later.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m = '{0, '0, '0, '0, '0, 1'b0};
    end else begin
      if (st0 && !busy0) m = '{0, '0, '0, '0, '0, 1'b0};
      if (in_valid && rdy0) begin
        m.sc = m.sc + 1;
        if (cur_ed != 0) m.ec = m.ec + 1;
        m.es = m.es + 64'(cur_ed);
        if (m.es > MAX52) begin
          m.es = MAX52;
          m.ov = 1'b1;
        end
        if (cur_ed > m.em) m.em = cur_ed;
        m.due = cyc + 2;
        q.push_back(m);
      end
    end
  end

  // Scoreboard pop: compare when the statistics are due.
  always @(negedge clk) begin
    if (!rst && q.size() > 0 && q[0].due == cyc) begin
      sb_t e;
      e = q.pop_front();
      chk("sb_sample_cnt", 64'(sc0), 64'(e.sc));
      chk("sb_err_cnt", 64'(ec0), 64'(e.ec));
      chk("sb_ed_sum", 64'(es0), e.es);
      chk("sb_ed_max", 64'(em0), 64'(e.em));
      chk("sb_sum_ovf", 64'(ov0), 64'(e.ov));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one sample for one cycle; returns at the following negedge.
  task automatic send(input vec_t v);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    r = v.r;
    cur_ed = v.ed;
    tick();
  endtask

  task automatic wait_done0(input string nm);
    int n = 0;
    while (!done0 && n < 50) begin
      tick();
      n++;
    end
    chk(nm, 64'(done0), 64'd1);
  endtask

  initial begin
    vec_t v;
    tv[0] = '{16'd3,     16'd5,     32'd15,         32'd0};
    tv[1] = '{16'd100,   16'd200,   32'd19990,      32'd10};
    tv[2] = '{16'd65535, 16'd65535, 32'd4294836225, 32'd0};
    tv[3] = '{16'd2,     16'd2,     32'd5,          32'd1};
    tv[4] = '{16'd7,     16'd9,     32'd63,         32'd0};
    tv[5] = '{16'd0,     16'd5,     32'd0,          32'd0};
    tv[6] = '{16'd1000,  16'd1000,  32'd1000000,    32'd0};
    tv[7] = '{16'd65535, 16'd1,     32'd65535,      32'd0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; r = '0;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", 64'(rdy0), 0);
    chk("rst_busy", 64'(busy0), 0);
    chk("rst_done", 64'(done0), 0);
    chk("rst_sample_cnt", 64'(sc0), 0);
    chk("rst_err_cnt", 64'(ec0), 0);
    chk("rst_ed_sum", 64'(es0), 0);
    chk("rst_ed_max", 64'(em0), 0);
    chk("rst_sum_ovf", 64'(ov0), 0);
    rst = 1'b0;
    tick();

    // Reset mid-run after two accepts.
    st0 = 1'b1; tick(); st0 = 1'b0;
    send(tv[0]); send(tv[1]);
    in_valid = 1'b0;
    tick(); tick();
    chk("mid_busy_before_rst", 64'(busy0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sample_cnt", 64'(sc0), 0);
    chk("mid_rst_ed_sum", 64'(es0), 0);
    chk("mid_rst_ed_max", 64'(em0), 0);
    chk("mid_rst_in_ready", 64'(rdy0), 0);
    chk("mid_rst_busy", 64'(busy0), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle_ready", 64'(rdy0), 0);
    chk("post_rst_idle_busy", 64'(busy0), 0);

    // Back-to-back run of four samples.
    st0 = 1'b1; tick(); st0 = 1'b0;
    chk("run_start_cnt_zero", 64'(sc0), 0);
    for (int i = 0; i < 4; i++) send(tv[i]);
    in_valid = 1'b0;
    chk("last_accept_ready", 64'(rdy0), 0);
    chk("last_accept_busy", 64'(busy0), 1);
    chk("last_accept_done", 64'(done0), 0);
    tick();
    chk("drain1_done", 64'(done0), 0);
    tick();
    chk("drain2_done", 64'(done0), 1);
    chk("b2b_sample_cnt", 64'(sc0), 4);
    chk("b2b_err_cnt", 64'(ec0), 2);
    chk("b2b_ed_sum", 64'(es0), 11);
    chk("b2b_ed_max", 64'(em0), 10);
    chk("b2b_sum_ovf", 64'(ov0), 0);
    chk("b2b_busy", 64'(busy0), 0);

    // Re-run with exact samples.
    st0 = 1'b1; tick(); st0 = 1'b0;
    chk("rerun_sample_cnt", 64'(sc0), 0);
    chk("rerun_err_cnt", 64'(ec0), 0);
    chk("rerun_ed_sum", 64'(es0), 0);
    chk("rerun_ed_max", 64'(em0), 0);
    chk("rerun_done", 64'(done0), 0);
    chk("rerun_busy", 64'(busy0), 1);
    chk("rerun_ready", 64'(rdy0), 1);
    for (int i = 4; i < 8; i++) send(tv[i]);
    in_valid = 1'b0;
    wait_done0("rerun_wait_done");
    chk("rerun_final_cnt", 64'(sc0), 4);
    chk("rerun_final_err", 64'(ec0), 0);
    chk("rerun_final_sum", 64'(es0), 0);

    // Gappy input, then a fifth sample held after the fourth accept.
    st0 = 1'b1; tick(); st0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v.a = 16'($urandom);
      v.b = 16'($urandom);
      v.r = 32'(v.a) * 32'(v.b) + 32'($urandom_range(0, 3));
      v.ed = ed_of(v.a, v.b, v.r);
      send(v);
      if (i < 3) begin
        in_valid = 1'b0;
        tick();
      end
    end
    chk("gap_ready_after_4th", 64'(rdy0), 0);
    v = '{16'd9, 16'd9, 32'd0, 32'd81};
    send(v); send(v); send(v); send(v);
    in_valid = 1'b0;
    wait_done0("gap_wait_done");
    chk("gap_sample_cnt", 64'(sc0), 4);

    // N=1, r above exact; start during DRAIN is ignored.
    st1 = 1'b1; tick(); st1 = 1'b0;
    send('{16'd0, 16'd0, 32'd7, 32'd7});
    in_valid = 1'b0;
    st1 = 1'b1; tick(); st1 = 1'b0;
    chk("n1_drain_busy", 64'(busy1), 1);
    tick();
    chk("n1_done", 64'(done1), 1);
    chk("n1_busy", 64'(busy1), 0);
    chk("n1_sample_cnt", 64'(sc1), 1);
    chk("n1_err_cnt", 64'(ec1), 1);
    chk("n1_ed_sum", 64'(es1), 7);
    chk("n1_ed_max", 64'(em1), 7);

    // Saturation with a 33-bit sum.
    st2 = 1'b1; tick(); st2 = 1'b0;
    for (int i = 0; i < 3; i++) send('{16'd65535, 16'd65535, 32'd0, 32'd4294836225});
    in_valid = 1'b0;
    tick();
    chk("sat_two_sum", 64'(es2), 64'd8589672450);
    chk("sat_two_ovf", 64'(ov2), 0);
    tick();
    chk("sat_done", 64'(done2), 1);
    chk("sat_ed_sum", 64'(es2), 64'd8589934591);
    chk("sat_sum_ovf", 64'(ov2), 1);
    chk("sat_ed_max", 64'(em2), 64'd4294836225);
    chk("sat_err_cnt", 64'(ec2), 3);
    chk("sat_sample_cnt", 64'(sc2), 3);

    repeat (2) tick();
    chk("sb_queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
